// File: rtl/mmc5_xram_arb.sv
// mmc5_xram_arb: three-port aging arbiter sequencing PPU, CPU and save-state accesses onto one single-port ExRAM
module mmc5_xram_arb #(
  parameter int WAIT_MAX = 4
) (
  input  logic       clk,
  input  logic       map_rst,
  input  logic [1:0] exram_mode,
  input  logic       ss_act,
  input  logic       ppu_stb,
  input  logic       cpu_stb,
  input  logic       ss_stb,
  input  logic       ppu_we,
  input  logic       cpu_we,
  input  logic       ss_we,
  input  logic [9:0] ppu_addr,
  input  logic [9:0] cpu_addr,
  input  logic [9:0] ss_addr,
  input  logic [7:0] ppu_din,
  input  logic [7:0] cpu_din,
  input  logic [7:0] ss_din,
  output logic       ppu_ack,
  output logic       cpu_ack,
  output logic       ss_ack,
  output logic [7:0] ppu_dout,
  output logic [7:0] cpu_dout,
  output logic [7:0] ss_dout,
  output logic       ppu_busy,
  output logic       cpu_busy,
  output logic       ss_busy,
  output logic       cpu_ovf,
  output logic [9:0] ram_addr,
  output logic       ram_we,
  output logic [7:0] ram_din,
  input  logic [7:0] ram_dout
);
  logic [2:0] stb, we_i, en, pend, p_we, busy, acc, cand, gnt, ack;
  logic [9:0] addr_i [3];
  logic [9:0] p_addr [3];
  logic [7:0] din_i [3];
  logic [7:0] p_din [3];
  logic [7:0] dout [3];
  logic [7:0] dout_q [3];
  logic [3:0] wait_ctr;
  logic [1:0] gi, s1_port, s2_port;
  logic       s1_vld, s1_rd, s1_zero, s2_vld, s2_rd, s2_zero;
  logic       g_we, we_ok, ram_we_q, ovf;
  logic [9:0] g_addr;
  logic [7:0] g_din, rd_val;
  assign stb = {ss_stb, cpu_stb, ppu_stb};
  assign we_i = {ss_we, cpu_we, ppu_we};
  assign addr_i = '{ppu_addr, cpu_addr, ss_addr};
  assign din_i = '{ppu_din, cpu_din, ss_din};
  // a save-state session owns the RAM exclusively; outside it the SS port is deaf
  assign en = {ss_act, ~ss_act, ~ss_act};
  always_comb begin
    rd_val = s2_zero ? 8'h00 : ram_dout;
    for (int i = 0; i < 3; i++) begin
      busy[i] = pend[i] | (s1_vld & (s1_port == 2'(i))) | (s2_vld & (s2_port == 2'(i)));
      acc[i] = stb[i] & ~busy[i] & en[i];
      cand[i] = (pend[i] | acc[i]) & en[i];
      ack[i] = s2_vld & (s2_port == 2'(i));
      dout[i] = (ack[i] & s2_rd) ? rd_val : dout_q[i];
    end
    gnt = cand[2] ? 3'b100 :
          (cand[1] & (~cand[0] | (wait_ctr >= 4'(WAIT_MAX)))) ? 3'b010 : {2'b00, cand[0]};
    gi = gnt[2] ? 2'd2 : gnt[1] ? 2'd1 : 2'd0;
    g_we = pend[gi] ? p_we[gi] : we_i[gi];
    g_addr = pend[gi] ? p_addr[gi] : addr_i[gi];
    g_din = pend[gi] ? p_din[gi] : din_i[gi];
    we_ok = gnt[0] ? ~exram_mode[1] : gnt[1] ? (exram_mode != 2'd3) : 1'b1;
  end
  always_ff @(posedge clk) begin
    if (map_rst) begin
      pend <= '0;
      p_we <= '0;
      wait_ctr <= '0;
      s1_vld <= 1'b0;
      s1_port <= '0;
      s1_rd <= 1'b0;
      s1_zero <= 1'b0;
      s2_vld <= 1'b0;
      s2_port <= '0;
      s2_rd <= 1'b0;
      s2_zero <= 1'b0;
      ram_we_q <= 1'b0;
      ram_addr <= '0;
      ram_din <= '0;
      ovf <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        p_addr[i] <= '0;
        p_din[i] <= '0;
        dout_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        pend[i] <= ~gnt[i] & en[i] & (pend[i] | acc[i]);
        if (acc[i]) begin
          p_we[i] <= we_i[i];
          p_addr[i] <= addr_i[i];
          p_din[i] <= din_i[i];
        end
        dout_q[i] <= dout[i];
      end
      wait_ctr <= gnt[1] ? 4'd0 : (cand[1] && wait_ctr != 4'd15) ? wait_ctr + 4'd1 : wait_ctr;
      s1_vld <= |gnt;
      s1_port <= gi;
      s1_rd <= ~g_we;
      s1_zero <= gnt[1] & ~exram_mode[1];
      s2_vld <= s1_vld;
      s2_port <= s1_port;
      s2_rd <= s1_rd;
      s2_zero <= s1_zero;
      ram_we_q <= (|gnt) & g_we & we_ok;
      if (|gnt) begin
        ram_addr <= g_addr;
        ram_din <= g_din;
      end
      ovf <= ovf | (cpu_stb & busy[1]);
    end
  end
  // the access cycle overlapping reset must not corrupt RAM
  assign ram_we = ram_we_q & ~map_rst;
  assign {ss_ack, cpu_ack, ppu_ack} = ack;
  assign {ss_busy, cpu_busy, ppu_busy} = busy;
  assign ppu_dout = dout[0];
  assign cpu_dout = dout[1];
  assign ss_dout = dout[2];
  assign cpu_ovf = ovf;
endmodule

// File: tb/tb_mmc5_xram_arb.sv
// tb_mmc5_xram_arb: transaction-level model of the ExRAM arbiter checked every cycle, plus pinned literal results
module tb_mmc5_xram_arb;
  localparam int WM = 4;
  logic clk = 0, map_rst = 1, ss_act = 0;
  logic [1:0] exram_mode = 0;
  logic ppu_stb = 0, cpu_stb = 0, ss_stb = 0, ppu_we = 0, cpu_we = 0, ss_we = 0;
  logic [9:0] ppu_addr = 0, cpu_addr = 0, ss_addr = 0;
  logic [7:0] ppu_din = 0, cpu_din = 0, ss_din = 0;
  logic ppu_ack, cpu_ack, ss_ack, ppu_busy, cpu_busy, ss_busy, cpu_ovf, ram_we;
  logic [7:0] ppu_dout, cpu_dout, ss_dout, ram_din, ram_dout;
  logic [9:0] ram_addr;
  logic [7:0] ram [1024];
  always #5 clk = ~clk;
  mmc5_xram_arb #(.WAIT_MAX(WM)) dut (
    .clk(clk), .map_rst(map_rst), .exram_mode(exram_mode), .ss_act(ss_act),
    .ppu_stb(ppu_stb), .cpu_stb(cpu_stb), .ss_stb(ss_stb),
    .ppu_we(ppu_we), .cpu_we(cpu_we), .ss_we(ss_we),
    .ppu_addr(ppu_addr), .cpu_addr(cpu_addr), .ss_addr(ss_addr),
    .ppu_din(ppu_din), .cpu_din(cpu_din), .ss_din(ss_din),
    .ppu_ack(ppu_ack), .cpu_ack(cpu_ack), .ss_ack(ss_ack),
    .ppu_dout(ppu_dout), .cpu_dout(cpu_dout), .ss_dout(ss_dout),
    .ppu_busy(ppu_busy), .cpu_busy(cpu_busy), .ss_busy(ss_busy), .cpu_ovf(cpu_ovf),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout)
  );
  always @(posedge clk) begin
    if (ram_we) begin
      ram[ram_addr] <= ram_din;
      ram_dout <= ram_din;
    end else ram_dout <= ram[ram_addr];
  end
  function automatic logic istb(int p); return p == 0 ? ppu_stb : p == 1 ? cpu_stb : ss_stb; endfunction
  function automatic logic iwe(int p); return p == 0 ? ppu_we : p == 1 ? cpu_we : ss_we; endfunction
  function automatic logic [9:0] iad(int p); return p == 0 ? ppu_addr : p == 1 ? cpu_addr : ss_addr; endfunction
  function automatic logic [7:0] idi(int p); return p == 0 ? ppu_din : p == 1 ? cpu_din : ss_din; endfunction
  function automatic logic oack(int p); return p == 0 ? ppu_ack : p == 1 ? cpu_ack : ss_ack; endfunction
  function automatic logic obusy(int p); return p == 0 ? ppu_busy : p == 1 ? cpu_busy : ss_busy; endfunction
  function automatic logic [7:0] odout(int p); return p == 0 ? ppu_dout : p == 1 ? cpu_dout : ss_dout; endfunction
  int tests = 0, fails = 0, cyc = 0;
  bit live = 0;
  int lit_cyc [32];
  int lit_port [32];
  logic [7:0] lit_val [32];
  int nlit = 0;
  function automatic void chk(string n, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s cyc %0d: got %0h expected %0h", n, cyc, act, exp);
    end
  endfunction
  bit m_pend [3];
  bit m_we [3];
  bit m_rd [3];
  logic [9:0] m_ad [3];
  logic [7:0] m_di [3];
  logic [7:0] m_val [3];
  logic [7:0] m_dout [3];
  int ack_at [3];
  logic [7:0] mem [1024];
  int wr_at = -10, wctr = 0;
  logic [9:0] wr_ad = 0;
  logic [7:0] wr_d = 0;
  bit m_ovf = 0;
  // the model tracks each request by the cycle its ack is due rather than by pipeline stages
  always @(negedge clk) begin
    bit bz [3];
    bit acc [3];
    bit cand [3];
    bit en [3];
    int g;
    bit gw, ok;
    logic [9:0] ga;
    logic [7:0] gd;
    if (live) begin
      for (int p = 0; p < 3; p++) begin
        if (ack_at[p] == cyc && m_rd[p]) m_dout[p] = m_val[p];
        chk($sformatf("ack%0d", p), oack(p), ack_at[p] == cyc);
        chk($sformatf("busy%0d", p), obusy(p), m_pend[p] || ack_at[p] >= cyc);
        chk($sformatf("dout%0d", p), odout(p), m_dout[p]);
      end
      chk("cpu_ovf", cpu_ovf, m_ovf);
      chk("ram_we", ram_we, wr_at == cyc && !map_rst);
      if (wr_at == cyc && !map_rst) begin
        chk("ram_addr", ram_addr, wr_ad);
        chk("ram_din", ram_din, wr_d);
      end
      for (int l = 0; l < nlit; l++) if (lit_cyc[l] == cyc) begin
        if (lit_port[l] < 3) begin
          chk($sformatf("lit_ack%0d", lit_port[l]), oack(lit_port[l]), 1);
          chk($sformatf("lit_dout%0d", lit_port[l]), odout(lit_port[l]), lit_val[l]);
        end else begin
          chk("lit_zero_ctl", {ppu_ack, cpu_ack, ss_ack, ppu_busy, cpu_busy, ss_busy, cpu_ovf, ram_we}, 0);
          chk("lit_zero_ram", {ram_addr, ram_din}, 0);
          chk("lit_zero_dout", {ppu_dout, cpu_dout, ss_dout}, 0);
        end
      end
    end
    if (map_rst) begin
      live = 1;
      for (int p = 0; p < 3; p++) begin
        m_pend[p] = 0;
        ack_at[p] = -10;
        m_dout[p] = 0;
      end
      wr_at = -10;
      wctr = 0;
      m_ovf = 0;
    end else begin
      if (wr_at == cyc) mem[wr_ad] = wr_d;
      for (int p = 0; p < 3; p++) begin
        bz[p] = m_pend[p] || ack_at[p] >= cyc;
        en[p] = (p == 2) ? ss_act : !ss_act;
        acc[p] = istb(p) && !bz[p] && en[p];
        cand[p] = (m_pend[p] || acc[p]) && en[p];
      end
      if (cpu_stb && bz[1]) m_ovf = 1;
      g = cand[2] ? 2 : (cand[1] && (!cand[0] || wctr >= WM)) ? 1 : cand[0] ? 0 : -1;
      if (g == 1) wctr = 0;
      else if (cand[1] && wctr < 15) wctr++;
      if (g >= 0) begin
        gw = m_pend[g] ? m_we[g] : iwe(g);
        ga = m_pend[g] ? m_ad[g] : iad(g);
        gd = m_pend[g] ? m_di[g] : idi(g);
        ok = g == 0 ? !exram_mode[1] : g == 1 ? exram_mode != 2'd3 : 1'b1;
        ack_at[g] = cyc + 2;
        m_rd[g] = !gw;
        m_val[g] = (g == 1 && !exram_mode[1]) ? 8'h00 : mem[ga];
        if (gw && ok) begin
          wr_at = cyc + 1;
          wr_ad = ga;
          wr_d = gd;
        end
      end
      for (int p = 0; p < 3; p++) begin
        if (acc[p] && p != g) begin
          m_we[p] = iwe(p);
          m_ad[p] = iad(p);
          m_di[p] = idi(p);
        end
        m_pend[p] = (p != g) && en[p] && (m_pend[p] || acc[p]);
      end
    end
    cyc++;
  end
  task automatic tick();
    @(posedge clk);
    #1;
    ppu_stb = 0;
    cpu_stb = 0;
    ss_stb = 0;
  endtask
  task automatic idle(int k);
    for (int i = 0; i < k; i++) tick();
  endtask
  task automatic req(int p, bit w, logic [9:0] a, logic [7:0] d);
    case (p)
      0: begin ppu_stb = 1; ppu_we = w; ppu_addr = a; ppu_din = d; end
      1: begin cpu_stb = 1; cpu_we = w; cpu_addr = a; cpu_din = d; end
      default: begin ss_stb = 1; ss_we = w; ss_addr = a; ss_din = d; end
    endcase
  endtask
  task automatic lit(int c, int p, logic [7:0] v);
    lit_cyc[nlit] = c;
    lit_port[nlit] = p;
    lit_val[nlit] = v;
    nlit++;
  endtask
  initial begin
    int n;
    tick();
    tick();
    map_rst = 0;
    req(0, 1, 10'h001, 8'h11);
    req(1, 1, 10'h3FF, 8'hEE);
    tick();
    map_rst = 1;
    req(1, 1, 10'h3FE, 8'h22);
    tick();
    map_rst = 0;
    lit(cyc, 3, 0);
    idle(3);
    exram_mode = 2;
    req(1, 1, 10'h123, 8'h5A);
    tick();
    idle(2);
    n = cyc;
    req(1, 0, 10'h123, 0);
    tick();
    lit(n + 2, 1, 8'h5A);
    idle(2);
    n = cyc;
    req(0, 0, 10'h123, 0);
    req(1, 0, 10'h123, 0);
    tick();
    lit(n + 2, 0, 8'h5A);
    lit(n + 3, 1, 8'h5A);
    idle(3);
    n = cyc;
    req(1, 0, 10'h123, 0);
    for (int i = 0; i < 8; i++) begin
      req(0, 0, 10'h123, 0);
      tick();
    end
    lit(n + 2, 0, 8'h5A);
    lit(n + 3, 1, 8'h5A);
    idle(3);
    req(1, 1, 10'h010, 8'h44);
    tick();
    idle(2);
    exram_mode = 3;
    req(1, 1, 10'h010, 8'h77);
    tick();
    idle(2);
    exram_mode = 2;
    n = cyc;
    req(1, 0, 10'h010, 0);
    tick();
    lit(n + 2, 1, 8'h44);
    idle(2);
    exram_mode = 0;
    n = cyc;
    req(1, 0, 10'h123, 0);
    tick();
    lit(n + 2, 1, 8'h00);
    idle(2);
    req(0, 1, 10'h020, 8'h33);
    tick();
    idle(2);
    exram_mode = 2;
    n = cyc;
    req(0, 0, 10'h020, 0);
    tick();
    lit(n + 2, 0, 8'h33);
    idle(2);
    n = cyc;
    req(1, 1, 10'h050, 8'h99);
    tick();
    req(0, 0, 10'h050, 0);
    tick();
    lit(n + 3, 0, 8'h99);
    idle(3);
    req(0, 0, 10'h123, 0);
    req(1, 0, 10'h123, 0);
    tick();
    ss_act = 1;
    tick();
    req(2, 1, 10'h3FF, 8'hAB);
    req(1, 1, 10'h3FF, 8'h00);
    tick();
    idle(2);
    n = cyc;
    req(2, 0, 10'h3FF, 0);
    tick();
    lit(n + 2, 2, 8'hAB);
    idle(2);
    ss_act = 0;
    req(2, 1, 10'h3FF, 8'h55);
    tick();
    idle(2);
    n = cyc;
    req(1, 0, 10'h3FF, 0);
    tick();
    lit(n + 2, 1, 8'hAB);
    req(1, 0, 10'h123, 0);
    tick();
    idle(4);
    map_rst = 1;
    tick();
    map_rst = 0;
    lit(cyc, 3, 0);
    idle(3);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
